people_counter: RTL

//  Produces the 3-bit customer count (pCount) consumed by the teller/queue FSM that forms con = {tCount, pCount}.

---
 rtl/people_counter.sv | 100 ++++++++++
 1 files changed

// File: rtl/people_counter.sv
// people_counter: door-sensor passage tracker driving a saturating occupancy count.
// Sensors are synchronized and debounced before a direction FSM decides entry/exit.
module people_counter #(
    parameter int CW         = 3,
    parameter int MAX_COUNT  = 7,
    parameter int DEB_CYCLES = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          sens_out,
    input  logic          sens_in,
    input  logic          clr,
    output logic [CW-1:0] pCount,
    output logic          full,
    output logic          empty,
    output logic          inc_p,
    output logic          dec_p,
    output logic          ovf_p,
    output logic          unf_p
);
    localparam int DW = DEB_CYCLES > 1 ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CW-1:0] MAXC = CW'(MAX_COUNT);
    localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, IN1, IN2, IN3, OUT1, OUT2, OUT3} state_t;

    logic [1:0]    s1_q, s2_q, deb_q, deb_d;
    logic [DW-1:0] cnt_q, cnt_d;
    state_t        state_q, state_d;
    logic [CW-1:0] pcount_q, pcount_d;
    logic [3:0]    pulse_q, pulse_d;
    logic          ev_in, ev_out;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_q     <= '0;
            s2_q     <= '0;
            deb_q    <= '0;
            cnt_q    <= '0;
            state_q  <= IDLE;
            pcount_q <= '0;
            pulse_q  <= '0;
        end else begin
            s1_q     <= {sens_out, sens_in};
            s2_q     <= s1_q;
            deb_q    <= deb_d;
            cnt_q    <= cnt_d;
            state_q  <= state_d;
            pcount_q <= pcount_d;
            pulse_q  <= pulse_d;
        end
    end

    // Window restarts whenever the synced pair agrees with the debounced pair again.
    always_comb begin
        deb_d = deb_q;
        cnt_d = '0;
        if (s2_q != deb_q) begin
            if (cnt_q == DEB_LAST) deb_d = s2_q;
            else cnt_d = cnt_q + 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: state_d = deb_q == 2'b10 ? IN1 : deb_q == 2'b01 ? OUT1 : IDLE;
            IN1:  state_d = deb_q == 2'b11 ? IN2 : deb_q == 2'b10 ? IN1 : IDLE;
            IN2:  state_d = deb_q == 2'b01 ? IN3 : deb_q == 2'b10 ? IN1 : deb_q == 2'b00 ? IDLE : IN2;
            IN3:  state_d = deb_q == 2'b11 ? IN2 : deb_q == 2'b01 ? IN3 : IDLE;
            OUT1: state_d = deb_q == 2'b11 ? OUT2 : deb_q == 2'b01 ? OUT1 : IDLE;
            OUT2: state_d = deb_q == 2'b10 ? OUT3 : deb_q == 2'b01 ? OUT1 : deb_q == 2'b00 ? IDLE : OUT2;
            OUT3: state_d = deb_q == 2'b11 ? OUT2 : deb_q == 2'b10 ? OUT3 : IDLE;
            default: state_d = state_q;
        endcase
    end

    assign ev_in  = state_q == IN3 && deb_q == 2'b00;
    assign ev_out = state_q == OUT3 && deb_q == 2'b00;

    // pulse bits: {inc, dec, ovf, unf}
    always_comb begin
        pcount_d = pcount_q;
        pulse_d  = '0;
        if (clr) begin
            pcount_d = '0;
        end else if (ev_in) begin
            pcount_d = pcount_q == MAXC ? pcount_q : pcount_q + 1'b1;
            pulse_d  = pcount_q == MAXC ? 4'b0010 : 4'b1000;
        end else if (ev_out) begin
            pcount_d = pcount_q == '0 ? pcount_q : pcount_q - 1'b1;
            pulse_d  = pcount_q == '0 ? 4'b0001 : 4'b0100;
        end
    end

    assign pCount = pcount_q;
    assign full   = pcount_q == MAXC;
    assign empty  = pcount_q == '0;
    assign {inc_p, dec_p, ovf_p, unf_p} = pulse_q;
endmodule
